// File: rtl/text_terminal_pkg.sv
// Shared display constants for the 40x8 text terminal.
// Also holds the FSM state type and the cell address helper.
package text_terminal_pkg;

  localparam int COLS  = 40;
  localparam int ROWS  = 8;
  localparam int CELLS = COLS * ROWS;

  localparam logic [7:0] CH_BS      = 8'h08;
  localparam logic [7:0] CH_LF      = 8'h0A;
  localparam logic [7:0] CH_FF      = 8'h0C;
  localparam logic [7:0] CH_CR      = 8'h0D;
  localparam logic [7:0] CH_ESC     = 8'h1B;
  localparam logic [7:0] CH_INV_ON  = 8'h70;
  localparam logic [7:0] CH_INV_OFF = 8'h71;
  localparam logic [7:0] CH_CUP     = 8'h59;
  localparam logic [7:0] CH_BLANK   = 8'h20;
  localparam logic [7:0] CH_TILDE   = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ESC,
    ST_ESCY_ROW,
    ST_ESCY_COL,
    ST_CLEAR
  } state_e;

  function automatic logic [8:0] cell_addr(
    input logic [2:0] row,
    input logic [5:0] col
  );
    return 9'(row) * 9'(COLS) + 9'(col);
  endfunction

endpackage

// File: rtl/text_terminal_byte_fifo.sv
// Synchronous byte FIFO, first-word fall-through.
// A push into a full FIFO is accepted only if a pop happens too.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/text_terminal.sv
// Byte-stream terminal front end: FIFO, escape parser,
// cursor, reverse video and clear sweeps into the text buffer.
module text_terminal
  import text_terminal_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe,
  output logic [8:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       wr_strobe,
  output logic [5:0] cursor_col,
  output logic [2:0] cursor_row,
  output logic       busy,
  output logic       overflow
);

  state_e     state_q, state_d;
  logic [5:0] col_q, col_d;
  logic [2:0] row_q, row_d;
  logic       inv_q, inv_d;
  logic [8:0] clr_next_q, clr_next_d;
  logic [8:0] clr_end_q, clr_end_d;
  logic [8:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       ovf_q;

  logic [7:0] rx_byte;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic [2:0] nl_row;
  logic [8:0] cur_addr;
  logic [8:0] nl_addr;
  logic [7:0] off;
  logic       low;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_strobe),
    .din_i   (rx_data),
    .pop_i   (pop),
    .dout_o  (rx_byte),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pop      = (state_q != ST_CLEAR) && !fifo_empty;
  assign nl_row   = (row_q == 3'(ROWS-1)) ? '0 : row_q + 3'd1;
  assign cur_addr = cell_addr(row_q, col_q);
  assign nl_addr  = cell_addr(nl_row, 6'd0);
  assign off      = rx_byte - CH_BLANK;
  assign low      = rx_byte < CH_BLANK;

  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_strobe  = wr_strobe_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign busy       = state_q == ST_CLEAR;
  assign overflow   = ovf_q;

  // State, cursor and registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      inv_q       <= 1'b0;
      clr_next_q  <= '0;
      clr_end_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strobe_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      inv_q       <= inv_d;
      clr_next_q  <= clr_next_d;
      clr_end_q   <= clr_end_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_strobe_q <= wr_strobe_d;
      if (rx_strobe && fifo_full && !pop)
        ovf_q <= 1'b1;
    end
  end

  // Byte interpretation and clear sweep sequencing.
  // A sweep entered by LF/FF issues its first cell at
  // once; an auto-wrap issues the character first.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    inv_d       = inv_q;
    clr_next_d  = clr_next_q;
    clr_end_d   = clr_end_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_strobe_d = 1'b0;
    if (state_q == ST_CLEAR) begin
      if (clr_next_q > clr_end_q) begin
        state_d = ST_IDLE;
      end else begin
        wr_strobe_d = 1'b1;
        wr_addr_d   = clr_next_q;
        wr_data_d   = CH_BLANK;
        clr_next_d  = clr_next_q + 9'd1;
      end
    end else if (pop) begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (1'b1)
            (rx_byte >= CH_BLANK &&
             rx_byte <= CH_TILDE): begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = cur_addr;
              wr_data_d   = {inv_q, rx_byte[6:0]};
              if (col_q == 6'(COLS-1)) begin
                col_d      = '0;
                row_d      = nl_row;
                clr_next_d = nl_addr;
                clr_end_d  = nl_addr + 9'(COLS-1);
                state_d    = ST_CLEAR;
              end else begin
                col_d = col_q + 6'd1;
              end
            end
            (rx_byte == CH_CR): col_d = '0;
            (rx_byte == CH_LF): begin
              row_d       = nl_row;
              wr_strobe_d = 1'b1;
              wr_addr_d   = nl_addr;
              wr_data_d   = CH_BLANK;
              clr_next_d  = nl_addr + 9'd1;
              clr_end_d   = nl_addr + 9'(COLS-1);
              state_d     = ST_CLEAR;
            end
            (rx_byte == CH_BS): begin
              if (col_q != '0) col_d = col_q - 6'd1;
            end
            (rx_byte == CH_FF): begin
              row_d       = '0;
              col_d       = '0;
              wr_strobe_d = 1'b1;
              wr_addr_d   = '0;
              wr_data_d   = CH_BLANK;
              clr_next_d  = 9'd1;
              clr_end_d   = 9'(CELLS-1);
              state_d     = ST_CLEAR;
            end
            (rx_byte == CH_ESC): state_d = ST_ESC;
            default: ;
          endcase
        end
        ST_ESC: begin
          state_d = ST_IDLE;
          unique case (1'b1)
            (rx_byte == CH_INV_ON):  inv_d = 1'b1;
            (rx_byte == CH_INV_OFF): inv_d = 1'b0;
            (rx_byte == CH_CUP): state_d = ST_ESCY_ROW;
            default: ;
          endcase
        end
        ST_ESCY_ROW: begin
          if (low) row_d = '0;
          else if (off > 8'(ROWS-1)) row_d = 3'(ROWS-1);
          else row_d = off[2:0];
          state_d = ST_ESCY_COL;
        end
        ST_ESCY_COL: begin
          if (low) col_d = '0;
          else if (off > 8'(COLS-1)) col_d = 6'(COLS-1);
          else col_d = off[5:0];
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_terminal.sv
// Self-checking bench for text_terminal.
// Reference model predicts the write stream and cursor.
module tb_text_terminal;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_strobe;
  logic [5:0] cursor_col;
  logic [2:0] cursor_row;
  logic       busy;
  logic       overflow;

  text_terminal #(.FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_strobe  (rx_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_strobe  (wr_strobe),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;
  int busy_cnt = 0;
  int bwr_cnt = 0;
  int wr_cnt = 0;

  logic [16:0] exp_q[$];
  logic [16:0] wlog[$];

  int mrow, mcol, mmode;
  bit minv;

  function automatic void chk(input string name,
                              input int act,
                              input int expv);
    nchk++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, expv, expv);
    end
  endfunction

  function automatic void m_reset();
    mrow = 0; mcol = 0; mmode = 0; minv = 0;
  endfunction

  function automatic void m_clear(input int a0, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({9'(a0 + i), 8'h20});
  endfunction

  function automatic void m_newline();
    mrow = (mrow + 1) % 8;
    m_clear(mrow * 40, 40);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int v;
    v = int'(b);
    case (mmode)
      0: begin
        if (v >= 32 && v <= 126) begin
          exp_q.push_back({9'(mrow * 40 + mcol),
                           minv, b[6:0]});
          mcol++;
          if (mcol == 40) begin
            mcol = 0;
            m_newline();
          end
        end else if (v == 13) mcol = 0;
        else if (v == 10) m_newline();
        else if (v == 8) begin
          if (mcol > 0) mcol--;
        end else if (v == 12) begin
          m_clear(0, 320);
          mrow = 0; mcol = 0;
        end else if (v == 27) mmode = 1;
      end
      1: begin
        mmode = 0;
        if (v == 112) minv = 1;
        else if (v == 113) minv = 0;
        else if (v == 89) mmode = 2;
      end
      2: begin
        mrow = (v < 32) ? 0 : ((v - 32 > 7) ? 7 : v - 32);
        mmode = 3;
      end
      default: begin
        mcol = (v < 32) ? 0 : ((v - 32 > 39) ? 39 : v - 32);
        mmode = 0;
      end
    endcase
  endfunction

  // Per-cycle comparison of every DUT write against the model.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cnt++;
      if (busy && wr_strobe) bwr_cnt++;
      if (wr_strobe) begin
        wr_cnt++;
        wlog.push_back({wr_addr, wr_data});
        if (exp_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL write_unexpected: got addr=%0d data=0x%0h expected none",
                   wr_addr, wr_data);
        end else begin
          chk("write", int'({wr_addr, wr_data}),
              int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_strobe = 1'b1;
    model_byte(b);
    @(negedge clk);
    rx_strobe = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int quiet;
    bit done;
    quiet = 0;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (!busy && !wr_strobe) quiet++;
      else quiet = 0;
      if (quiet >= 4 && exp_q.size() == 0) done = 1;
    end
    if (!done)
      $display("FAIL %s_timeout: got pending=%0d expected 0",
               tag, exp_q.size());
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic chk_cursor(input string tag,
                            input int r, input int c);
    chk({tag, "_row"}, int'(cursor_row), r);
    chk({tag, "_col"}, int'(cursor_col), c);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rx_data = 8'h00;
    rx_strobe = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_strobe", int'(wr_strobe), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk_cursor("rst", 0, 0);
    reset = 1'b0;
    @(negedge clk);

    send_byte(8'h48);
    @(negedge clk);
    chk("hi_h_strobe", int'(wr_strobe), 1);
    chk("hi_h_addr", int'(wr_addr), 0);
    chk("hi_h_data", int'(wr_data), 8'h48);
    chk("hi_h_col", int'(cursor_col), 1);
    send_byte(8'h49);
    @(negedge clk);
    chk("hi_i_strobe", int'(wr_strobe), 1);
    chk("hi_i_addr", int'(wr_addr), 1);
    chk("hi_i_data", int'(wr_data), 8'h49);
    wait_idle("hi");
    chk_cursor("hi", 0, 2);

    busy_cnt = 0; bwr_cnt = 0;
    send_byte(8'h0C);
    wait_idle("ff");
    chk("ff_busy_cycles", busy_cnt, 320);
    chk("ff_busy_writes", bwr_cnt, 320);
    chk_cursor("ff", 0, 0);

    send_byte(8'h1B); send_byte(8'h59);
    send_byte(8'h27); send_byte(8'h21);
    wait_idle("cup");
    chk_cursor("cup", 7, 1);
    busy_cnt = 0; bwr_cnt = 0;
    wlog.delete();
    send_byte(8'h0A);
    wait_idle("lf");
    chk("lf_busy_cycles", busy_cnt, 40);
    chk("lf_writes", wlog.size(), 40);
    if (wlog.size() == 40) begin
      chk("lf_first", int'(wlog[0]), int'({9'd0, 8'h20}));
      chk("lf_last", int'(wlog[39]), int'({9'd39, 8'h20}));
    end
    chk_cursor("lf", 0, 1);

    send_byte(8'h0C);
    wait_idle("ff2");
    wlog.delete();
    send_byte(8'h1B); send_byte(8'h70); send_byte(8'h41);
    send_byte(8'h1B); send_byte(8'h71); send_byte(8'h41);
    wait_idle("inv");
    chk("inv_writes", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("inv_on", int'(wlog[0]), int'({9'd0, 8'hC1}));
      chk("inv_off", int'(wlog[1]), int'({9'd1, 8'h41}));
    end

    send_byte(8'h0C);
    wait_idle("ff3");
    wlog.delete();
    for (int i = 0; i < 41; i++) send_byte(8'h78);
    wait_idle("wrap");
    chk("wrap_writes", wlog.size(), 81);
    if (wlog.size() == 81) begin
      chk("wrap_39", int'(wlog[39]), int'({9'd39, 8'h78}));
      chk("wrap_clr0", int'(wlog[40]), int'({9'd40, 8'h20}));
      chk("wrap_clr39", int'(wlog[79]), int'({9'd79, 8'h20}));
      chk("wrap_41st", int'(wlog[80]), int'({9'd40, 8'h78}));
    end
    chk_cursor("wrap", 1, 1);

    send_byte(8'h1B); send_byte(8'h59);
    send_byte(8'h10); send_byte(8'h7F);
    wait_idle("clamp");
    chk_cursor("clamp", 0, 39);
    send_byte(8'h5A);
    send_byte(8'h0D);
    send_byte(8'h08);
    send_byte(8'h07);
    wait_idle("bs");
    chk_cursor("bs", 1, 0);

    chk("ovf_before", int'(overflow), 0);
    send_byte(8'h0C);
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    chk("ovf_busy", int'(busy), 1);
    wlog.delete();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rx_data = 8'h61 + 8'(i);
      rx_strobe = 1'b1;
      if (i < 16) model_byte(rx_data);
    end
    @(negedge clk);
    rx_strobe = 1'b0;
    wait_idle("ovf");
    chk("ovf_after", int'(overflow), 1);
    chk("ovf_writes", wlog.size(), 336);
    if (wlog.size() == 336) begin
      chk("ovf_first", int'(wlog[320]), int'({9'd0, 8'h61}));
      chk("ovf_16th", int'(wlog[335]), int'({9'd15, 8'h70}));
    end
    chk_cursor("ovf", 0, 16);

    send_byte(8'h0C);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    m_reset();
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_strobe", int'(wr_strobe), 0);
    chk("abort_ovf", int'(overflow), 0);
    chk_cursor("abort", 0, 0);
    reset = 1'b0;
    wr_cnt = 0;
    repeat (8) @(negedge clk);
    chk("abort_quiet", wr_cnt, 0);
    chk("abort_idle", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
